// File: rtl/axi4_mem_responder_pkg.sv
// rtl/axi4_mem_responder_pkg.sv - AXI response codes and sizing helpers shared by the memory responder
package axi4_mem_responder_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t AXI_RESP_OKAY   = 2'b00;
  localparam axi_resp_t AXI_RESP_SLVERR = 2'b10;

  // Width of a word index into a memory of n words; never below 1 so ports stay legal.
  function automatic int idx_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi4_mem_responder_if.sv
// rtl/axi4_mem_responder_if.sv - AXI4 read/write channel bundle between master and memory responder
interface axi4_mem_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 6
) ();

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [ID_W-1:0]   arid;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [ID_W-1:0]   rid;

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [ID_W-1:0]   awid;

  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;

  logic            bvalid;
  logic            bready;
  logic [1:0]      bresp;
  logic [ID_W-1:0] bid;

  modport master (
    output arvalid, araddr, arlen, arid, input arready,
    input rvalid, rdata, rresp, rlast, rid, output rready,
    output awvalid, awaddr, awlen, awid, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input bvalid, bresp, bid, output bready
  );

  modport slave (
    input arvalid, araddr, arlen, arid, output arready,
    output rvalid, rdata, rresp, rlast, rid, input rready,
    input awvalid, awaddr, awlen, awid, output awready,
    input wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bresp, bid, input bready
  );

endinterface

// File: rtl/axi4_mem_responder_ram.sv
// rtl/axi4_mem_responder_ram.sv - word memory with a combinational read port and a byte-enabled write port
module axi4_mem_responder_ram #(
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic                clk,
  input  logic [IDX_W-1:0]    raddr,
  output logic [DATA_W-1:0]   rdata,
  input  logic                we,
  input  logic [IDX_W-1:0]    waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Read sees pre-edge contents, so a same-cycle write to the same word returns old data.
  assign rdata = mem[raddr];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (wstrb[b]) begin
          mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/axi4_mem_responder.sv
// rtl/axi4_mem_responder.sv - AXI4 responder model: single-outstanding INCR bursts onto a small word memory
module axi4_mem_responder
  import axi4_mem_responder_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int ID_W         = 6,
  parameter int DEPTH_WORDS  = 256,
  parameter int READ_LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  axi4_mem_responder_if.slave bus
);

  localparam int BYTE_SHIFT = $clog2(DATA_W / 8);
  localparam int IDX_W      = idx_width(DEPTH_WORDS);
  // One extra index bit catches bursts that run past the top of the address space.
  localparam logic [ADDR_W:0] DEPTH_LIMIT = (ADDR_W + 1)'(DEPTH_WORDS);
  localparam logic [ADDR_W:0] IDX_ONE     = (ADDR_W + 1)'(1);
  localparam logic [3:0]      LAT_LOAD    = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  r_state_t        r_state, r_state_next;
  logic [ADDR_W:0] r_idx;
  logic [7:0]      r_cnt;
  logic [3:0]      r_lat;
  logic [ID_W-1:0] r_id;

  w_state_t        w_state, w_state_next;
  logic [ADDR_W:0] w_idx;
  logic [7:0]      w_cnt;
  logic [ID_W-1:0] w_id;
  logic            w_err;

  logic              r_in_range, w_in_range;
  logic              ar_fire, r_fire, aw_fire, w_fire, b_fire;
  logic              w_we;
  logic [DATA_W-1:0] ram_rdata;
  logic              unused_wlast;

  assign unused_wlast = bus.wlast;
  assign r_in_range   = (r_idx < DEPTH_LIMIT);
  assign w_in_range   = (w_idx < DEPTH_LIMIT);

  assign ar_fire = bus.arvalid & bus.arready;
  assign r_fire  = bus.rvalid & bus.rready;
  assign aw_fire = bus.awvalid & bus.awready;
  assign w_fire  = bus.wvalid & bus.wready;
  assign b_fire  = bus.bvalid & bus.bready;

  assign bus.rid = r_id;
  assign bus.bid = w_id;

  axi4_mem_responder_ram #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk   (clk),
    .raddr (r_idx[IDX_W-1:0]),
    .rdata (ram_rdata),
    .we    (w_we),
    .waddr (w_idx[IDX_W-1:0]),
    .wdata (bus.wdata),
    .wstrb (bus.wstrb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
    end else begin
      r_state <= r_state_next;
    end
  end

  // Readys are masked by rst so nothing is accepted while reset is held.
  always_comb begin
    r_state_next = r_state;
    bus.arready  = 1'b0;
    bus.rvalid   = 1'b0;
    bus.rlast    = 1'b0;
    bus.rresp    = AXI_RESP_OKAY;
    bus.rdata    = '0;
    case (r_state)
      R_IDLE: begin
        bus.arready = ~rst;
        if (bus.arvalid && !rst) begin
          r_state_next = R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_lat == 4'd0) begin
          r_state_next = R_DATA;
        end
      end
      R_DATA: begin
        bus.rvalid = 1'b1;
        bus.rlast  = (r_cnt == 8'd0);
        bus.rresp  = r_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        bus.rdata  = r_in_range ? ram_rdata : '0;
        if (bus.rready && r_cnt == 8'd0) begin
          r_state_next = R_IDLE;
        end
      end
      default: r_state_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
      r_cnt <= '0;
      r_lat <= '0;
      r_id  <= '0;
    end else begin
      if (ar_fire) begin
        r_idx <= {1'b0, bus.araddr} >> BYTE_SHIFT;
        r_cnt <= bus.arlen;
        r_lat <= LAT_LOAD;
        r_id  <= bus.arid;
      end else if (r_state == R_WAIT && r_lat != 4'd0) begin
        r_lat <= r_lat - 4'd1;
      end
      if (r_fire) begin
        r_idx <= r_idx + IDX_ONE;
        r_cnt <= r_cnt - 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
    end else begin
      w_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = w_state;
    bus.awready  = 1'b0;
    bus.wready   = 1'b0;
    bus.bvalid   = 1'b0;
    bus.bresp    = AXI_RESP_OKAY;
    w_we         = 1'b0;
    case (w_state)
      W_IDLE: begin
        bus.awready = ~rst;
        if (bus.awvalid && !rst) begin
          w_state_next = W_DATA;
        end
      end
      W_DATA: begin
        bus.wready = ~rst;
        if (bus.wvalid && !rst) begin
          w_we = w_in_range;
          if (w_cnt == 8'd0) begin
            w_state_next = W_RESP;
          end
        end
      end
      W_RESP: begin
        bus.bvalid = 1'b1;
        bus.bresp  = w_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        if (bus.bready) begin
          w_state_next = W_IDLE;
        end
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_idx <= '0;
      w_cnt <= '0;
      w_id  <= '0;
      w_err <= 1'b0;
    end else begin
      if (aw_fire) begin
        w_idx <= {1'b0, bus.awaddr} >> BYTE_SHIFT;
        w_cnt <= bus.awlen;
        w_id  <= bus.awid;
      end
      if (w_fire) begin
        w_idx <= w_idx + IDX_ONE;
        w_cnt <= w_cnt - 8'd1;
        if (!w_in_range) begin
          w_err <= 1'b1;
        end
      end
      if (b_fire) begin
        w_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi4_mem_responder.sv
// tb/tb_axi4_mem_responder.sv - directed self-checking bench for axi4_mem_responder
module tb_axi4_mem_responder;

  logic clk;
  logic rst;

  axi4_mem_responder_if #(.ADDR_W(32), .DATA_W(32), .ID_W(6)) bus ();

  axi4_mem_responder #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .ID_W         (6),
    .DEPTH_WORDS  (256),
    .READ_LATENCY (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_data [8];
  logic [1:0]  exp_resp [8];
  logic [31:0] wr_data  [8];
  logic [3:0]  wr_strb  [8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic read_burst(input logic [31:0] addr, input int len, input logic [5:0] id);
    int lat;
    check("rd_arready", 64'(bus.arready), 64'd1);
    bus.arvalid = 1'b1;
    bus.araddr  = addr;
    bus.arlen   = 8'(len);
    bus.arid    = id;
    bus.rready  = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    lat = 0;
    while (!bus.rvalid && lat < 20) begin
      tick();
      lat++;
    end
    check("rd_latency", 64'(lat), 64'd3);
    for (int b = 0; b <= len; b++) begin
      check("rd_rvalid", 64'(bus.rvalid), 64'd1);
      check("rd_rdata", 64'(bus.rdata), 64'(exp_data[b]));
      check("rd_rresp", 64'(bus.rresp), 64'(exp_resp[b]));
      check("rd_rid", 64'(bus.rid), 64'(id));
      check("rd_rlast", 64'(bus.rlast), 64'(b == len));
      tick();
    end
    check("rd_done", 64'(bus.rvalid), 64'd0);
    bus.rready = 1'b0;
  endtask

  task automatic write_burst(input logic [31:0] addr, input int len, input logic [5:0] id,
                             input logic [1:0] exp_b);
    check("wr_awready", 64'(bus.awready), 64'd1);
    bus.awvalid = 1'b1;
    bus.awaddr  = addr;
    bus.awlen   = 8'(len);
    bus.awid    = id;
    bus.bready  = 1'b0;
    tick();
    bus.awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      bus.wvalid = 1'b1;
      bus.wdata  = wr_data[b];
      bus.wstrb  = wr_strb[b];
      bus.wlast  = (b == len);
      check("wr_wready", 64'(bus.wready), 64'd1);
      tick();
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    check("wr_bvalid", 64'(bus.bvalid), 64'd1);
    check("wr_bid", 64'(bus.bid), 64'(id));
    check("wr_bresp", 64'(bus.bresp), 64'(exp_b));
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    check("wr_bdone", 64'(bus.bvalid), 64'd0);
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    bus.arvalid = 1'b0; bus.araddr = '0; bus.arlen = '0; bus.arid = '0;
    bus.rready  = 1'b0;
    bus.awvalid = 1'b0; bus.awaddr = '0; bus.awlen = '0; bus.awid = '0;
    bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb = '0; bus.wlast = 1'b0;
    bus.bready  = 1'b0;
    repeat (3) tick();

    check("rst_arready", 64'(bus.arready), 64'd0);
    check("rst_awready", 64'(bus.awready), 64'd0);
    check("rst_wready", 64'(bus.wready), 64'd0);
    check("rst_rvalid", 64'(bus.rvalid), 64'd0);
    check("rst_bvalid", 64'(bus.bvalid), 64'd0);
    check("rst_rlast", 64'(bus.rlast), 64'd0);
    check("rst_rdata", 64'(bus.rdata), 64'd0);
    check("rst_rresp", 64'(bus.rresp), 64'd0);
    check("rst_rid", 64'(bus.rid), 64'd0);
    check("rst_bid", 64'(bus.bid), 64'd0);
    check("rst_bresp", 64'(bus.bresp), 64'd0);
    rst = 1'b0;
    tick();
    check("post_rst_arready", 64'(bus.arready), 64'd1);
    check("post_rst_awready", 64'(bus.awready), 64'd1);

    // Single read: latency, ID echo, arready held low until after the R accept
    bus.arvalid = 1'b1; bus.araddr = 32'h10; bus.arlen = 8'd0; bus.arid = 6'd5;
    bus.rready  = 1'b0;
    tick();
    bus.arvalid = 1'b0;
    lat = 0;
    while (!bus.rvalid && lat < 20) begin
      check("t1_arready_wait", 64'(bus.arready), 64'd0);
      tick();
      lat++;
    end
    check("t1_latency", 64'(lat), 64'd3);
    check("t1_rid", 64'(bus.rid), 64'd5);
    check("t1_rlast", 64'(bus.rlast), 64'd1);
    check("t1_rresp", 64'(bus.rresp), 64'd0);
    check("t1_arready_data", 64'(bus.arready), 64'd0);
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    check("t1_rvalid_done", 64'(bus.rvalid), 64'd0);
    check("t1_arready_back", 64'(bus.arready), 64'd1);

    // Write burst with W offered before AW, then readback
    bus.wvalid = 1'b1; bus.wdata = 32'hA; bus.wstrb = 4'hF;
    check("t2_wready_pre_aw0", 64'(bus.wready), 64'd0);
    tick();
    check("t2_wready_pre_aw1", 64'(bus.wready), 64'd0);
    bus.awvalid = 1'b1; bus.awaddr = 32'h0; bus.awlen = 8'd3; bus.awid = 6'd9;
    bus.bready  = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.wdata = 32'hA + 32'(i);
      bus.wlast = (i == 3);
      check("t2_wready", 64'(bus.wready), 64'd1);
      tick();
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    check("t2_bvalid", 64'(bus.bvalid), 64'd1);
    check("t2_bid", 64'(bus.bid), 64'd9);
    check("t2_bresp", 64'(bus.bresp), 64'd0);
    tick();
    bus.bready = 1'b0;
    check("t2_bvalid_done", 64'(bus.bvalid), 64'd0);
    exp_data[0] = 32'hA; exp_data[1] = 32'hB; exp_data[2] = 32'hC; exp_data[3] = 32'hD;
    for (int i = 0; i < 4; i++) exp_resp[i] = 2'b00;
    read_burst(32'h0, 3, 6'd2);

    // Partial strobe merge
    wr_data[0] = 32'h11223344; wr_strb[0] = 4'hF;
    write_burst(32'h0, 0, 6'd1, 2'b00);
    wr_data[0] = 32'hAABBCCDD; wr_strb[0] = 4'b0101;
    write_burst(32'h0, 0, 6'd1, 2'b00);
    exp_data[0] = 32'h11BB33DD; exp_resp[0] = 2'b00;
    read_burst(32'h0, 0, 6'd3);

    // Burst crossing the top of memory: first beat lands, second is an error
    wr_data[0] = 32'h55; wr_strb[0] = 4'hF;
    wr_data[1] = 32'h66; wr_strb[1] = 4'hF;
    write_burst(32'h3FC, 1, 6'd4, 2'b10);
    exp_data[0] = 32'h55; exp_resp[0] = 2'b00;
    exp_data[1] = 32'h0;  exp_resp[1] = 2'b10;
    read_burst(32'h3FC, 1, 6'd6);
    exp_data[0] = 32'h0; exp_resp[0] = 2'b10;
    read_burst(32'h400, 0, 6'd8);

    // R backpressure on beat 1 of a 3-beat read
    bus.arvalid = 1'b1; bus.araddr = 32'h4; bus.arlen = 8'd2; bus.arid = 6'd7;
    bus.rready  = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    lat = 0;
    while (!bus.rvalid && lat < 20) begin
      tick();
      lat++;
    end
    check("t5_latency", 64'(lat), 64'd3);
    check("t5_beat0", 64'(bus.rdata), 64'hB);
    tick();
    bus.rready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t5_hold_rvalid", 64'(bus.rvalid), 64'd1);
      check("t5_hold_rdata", 64'(bus.rdata), 64'hC);
      check("t5_hold_rid", 64'(bus.rid), 64'd7);
      check("t5_hold_rlast", 64'(bus.rlast), 64'd0);
      tick();
    end
    bus.rready = 1'b1;
    check("t5_beat1", 64'(bus.rdata), 64'hC);
    tick();
    check("t5_beat2", 64'(bus.rdata), 64'hD);
    check("t5_beat2_last", 64'(bus.rlast), 64'd1);
    tick();
    bus.rready = 1'b0;
    check("t5_rvalid_done", 64'(bus.rvalid), 64'd0);

    // B backpressure with a second AW pending; error flag from before must be clear
    bus.awvalid = 1'b1; bus.awaddr = 32'h20; bus.awlen = 8'd0; bus.awid = 6'd3;
    bus.bready  = 1'b0;
    tick();
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b1; bus.wdata = 32'h77; bus.wstrb = 4'hF; bus.wlast = 1'b1;
    tick();
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    bus.awvalid = 1'b1; bus.awaddr = 32'h24; bus.awid = 6'd4;
    for (int i = 0; i < 3; i++) begin
      check("t6_hold_bvalid", 64'(bus.bvalid), 64'd1);
      check("t6_hold_bid", 64'(bus.bid), 64'd3);
      check("t6_hold_bresp", 64'(bus.bresp), 64'd0);
      check("t6_no_aw", 64'(bus.awready), 64'd0);
      tick();
    end
    bus.awvalid = 1'b0;
    bus.bready  = 1'b1;
    tick();
    bus.bready = 1'b0;
    check("t6_bvalid_done", 64'(bus.bvalid), 64'd0);
    check("t6_awready_back", 64'(bus.awready), 64'd1);
    exp_data[0] = 32'h77; exp_resp[0] = 2'b00;
    read_burst(32'h20, 0, 6'd1);

    // Reset during beat 2 of an 8-beat read
    bus.arvalid = 1'b1; bus.araddr = 32'h0; bus.arlen = 8'd7; bus.arid = 6'd12;
    bus.rready  = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    lat = 0;
    while (!bus.rvalid && lat < 20) begin
      tick();
      lat++;
    end
    check("t7_latency", 64'(lat), 64'd3);
    tick();
    tick();
    check("t7_beat2_valid", 64'(bus.rvalid), 64'd1);
    check("t7_beat2_data", 64'(bus.rdata), 64'hC);
    rst = 1'b1;
    tick();
    check("t7_rst_rvalid", 64'(bus.rvalid), 64'd0);
    check("t7_rst_arready", 64'(bus.arready), 64'd0);
    tick();
    check("t7_rst_arready2", 64'(bus.arready), 64'd0);
    rst = 1'b0;
    tick();
    check("t7_arready_back", 64'(bus.arready), 64'd1);
    check("t7_rvalid_idle", 64'(bus.rvalid), 64'd0);
    repeat (5) tick();
    check("t7_no_stray_r", 64'(bus.rvalid), 64'd0);
    bus.rready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
